// File: rtl/echo_pkg.sv
// echo_pkg: shared display codes, segment constants and the hex glyph table
package echo_pkg;
  localparam logic [4:0] CODE_BLANK = 5'b00000;
  localparam logic [4:0] CODE_DASH = 5'b00001;
  localparam int VALID_BIT = 4;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  // abcdefg, a in bit 6
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
endpackage

// File: rtl/echo_codificador.sv
// echo_codificador: priority-encodes enable/dash/nibble into a registered 5-bit code
module echo_codificador
  import echo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic RE,
  input  logic RS,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic S4,
  output logic S5
);
  logic [4:0] code, q;
  always_comb code = !RE ? CODE_BLANK : RS ? CODE_DASH : {1'b1, A, B, C, D};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= CODE_BLANK;
    else q <= code;
  assign {S1, S2, S3, S4, S5} = q;
endmodule

// File: rtl/echo_display.sv
// echo_display: decodes the 5-bit display code into registered active-high segments
module echo_display
  import echo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic SD1,
  input  logic SD2,
  input  logic SD3,
  input  logic SD4,
  input  logic SD5,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);
  logic [4:0] code;
  logic [6:0] seg, q;
  assign code = {SD1, SD2, SD3, SD4, SD5};
  always_comb seg = code[VALID_BIT] ? GLYPH[code[3:0]] : code == CODE_DASH ? SEG_DASH : SEG_OFF;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEG_OFF;
    else q <= seg;
  assign {a, b, c, d, e, f, g} = q;
endmodule

// File: rtl/echo_encoder_display.sv
// echo_encoder_display: two-stage switch-to-7-segment pipeline exposing the intermediate code
module echo_encoder_display (
  input  logic clk,
  input  logic rst_n,
  input  logic RE,
  input  logic RS,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic S4,
  output logic S5,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);
  echo_codificador u_enc (
    .clk(clk), .rst_n(rst_n), .RE(RE), .RS(RS), .A(A), .B(B), .C(C), .D(D),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5)
  );
  echo_display u_disp (
    .clk(clk), .rst_n(rst_n), .SD1(S1), .SD2(S2), .SD3(S3), .SD4(S4), .SD5(S5),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );
endmodule

// File: tb/tb_echo_encoder_display.sv
// tb_echo_encoder_display: randomized scoreboard bench against a behavioural model of the switch-to-digit path
module tb_echo_encoder_display;
  logic clk = 0, rst_n = 0;
  logic RE = 0, RS = 0, A = 0, B = 0, C = 0, D = 0;
  logic S1, S2, S3, S4, S5, a, b, c, d, e, f, g;
  logic [4:0] s;
  logic [6:0] seg;
  int compared = 0, mismatched = 0;
  bit run = 0;
  logic [4:0] cq[$];
  logic [6:0] sq[$];
  localparam logic [6:0] HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  echo_encoder_display dut (
    .clk(clk), .rst_n(rst_n), .RE(RE), .RS(RS), .A(A), .B(B), .C(C), .D(D),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clk = ~clk;
  assign s = {S1, S2, S3, S4, S5};
  assign seg = {a, b, c, d, e, f, g};

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic rs, input logic [3:0] n);
    RE = re; RS = rs; {A, B, C, D} = n;
    cq.push_back(!re ? 5'd0 : rs ? 5'd1 : 5'd16 + {1'b0, n});
    sq.push_back(!re ? 7'h00 : rs ? 7'h01 : HEX[n]);
  endtask

  task automatic step(input logic re, input logic rs, input logic [3:0] n);
    @(posedge clk); #1;
    drive(re, rs, n);
  endtask

  task automatic release_rst(input logic re, input logic rs, input logic [3:0] n);
    @(negedge clk); #1;
    rst_n = 1;
    sq.push_back(7'h00);
    drive(re, rs, n);
    run = 1;
  endtask

  task automatic do_reset(input logic re, input logic rs, input logic [3:0] n);
    @(posedge clk); #3;
    run = 0;
    rst_n = 0;
    #1;
    chk("rst_code_now", {2'b0, s}, 7'h00);
    chk("rst_seg_now", seg, 7'h00);
    cq.delete(); sq.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code_held", {2'b0, s}, 7'h00);
    chk("rst_seg_held", seg, 7'h00);
    release_rst(re, rs, n);
  endtask

  always @(negedge clk)
    if (run) begin
      if (cq.size() == 0 || sq.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
      end else begin
        chk("code", {2'b0, s}, {2'b0, cq.pop_front()});
        chk("seg", seg, sq.pop_front());
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RE = 1; {A, B, C, D} = 4'hF;
    #12;
    chk("por_code", {2'b0, s}, 7'h00);
    chk("por_seg", seg, 7'h00);
    release_rst(1, 0, 4'hF);
    repeat (3) step(1, 0, 4'hF);
    do_reset(1, 0, 4'hF);
    repeat (2) step(1, 0, 4'hF);
    for (int i = 0; i < 16; i++) step(1, 0, 4'(i));
    step(0, 1, 4'h8);
    step(1, 0, 4'h8);
    step(1, 0, 4'h8);
    step(1, 1, 4'h7);
    repeat (4) step(1, 1, 4'($urandom_range(15)));
    repeat (2) step(1, 0, 4'h0);
    step(1, 0, 4'h1);
    repeat (2) step(1, 0, 4'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 4'(i));
    do_reset(1, 0, 4'h9);
    for (int i = 10; i < 16; i++) step(1, 0, 4'(i));
    repeat (300) step(1'($urandom_range(1)), 1'($urandom_range(3) == 0), 4'($urandom_range(15)));
    do_reset(1'($urandom_range(1)), 0, 4'($urandom_range(15)));
    repeat (40) step(1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)));
    @(negedge clk); #1;
    run = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/echo_encoder_display.md
# echo_encoder_display

- Registered two-stage path from a 4-bit nibble input with control flags to a 7-segment display.
- Stage 1, `echo_codificador`, packs the controls and nibble into a 5-bit display code S1..S5.
- Stage 2, `echo_display`, decodes that code into active-high segments a..g.
- The top wraps both stages, exposes the intermediate code for observation, and sits between the board input switches and a single 7-segment digit.

## Interface

- No parameters.

Clock and reset:

- One clock; reset is asynchronous and active-low.
- `clk` – in – 1 – single clock, rising-edge.
- `rst_n` – in – 1 – asynchronous, active-low reset.

Control and data inputs:

- `RE` – in – 1 – display enable; 0 blanks the digit.
- `RS` – in – 1 – reset-show; 1 while enabled forces a dash.
- `A`, `B`, `C`, `D` – in – 1 each – nibble, A = MSB, D = LSB.

Outputs:

- `S1`..`S5` – out – 1 each – registered code; S1 = MSB.
- `a`..`g` – out – 1 each – registered segments, active-high, standard a..g labelling.

## Operation

The encoder forms the code `{S1,S2,S3,S4,S5}` from the inputs, in priority order:

- `RE`=0 → `00000` (blank).
- `RE`=1, `RS`=1 → `00001` (dash); A..D are ignored.
- `RE`=1, `RS`=0 → `{1,A,B,C,D}` (digit valid, value = ABCD).

The display decodes the code `{S1..S5}`:

- S1=1 → hex glyph of `{S2..S5}`.
- `00001` → only segment g lit (`abcdefg`=0000001).
- Every other code with S1=0 → all segments off.

Hex glyphs as `abcdefg`:

- 0=1111110, 1=0110000, 2=1101101, 3=1111001
- 4=0110011, 5=1011011, 6=1011111, 7=1110000
- 8=1111111, 9=1111011, A=1110111, b=0011111
- C=1001110, d=0111101, E=1001111, F=1000111

Additional rules:

- The display is purely a function of the registered code. It has no state of its own beyond its output register.

## Timing

- The encoder samples RE, RS and A..D on each rising `clk`. S1..S5 update at that edge, giving 1-cycle latency from inputs.
- The display samples S1..S5 on the next rising edge. a..g change 2 cycles after the input change.
- While `rst_n`=0:
  - S1..S5 = `00000`.
  - a..g = `0000000`, which is the blank digit.
  - The clock is ignored.
- Reset assertion takes effect immediately, without waiting for a clock edge.
- On release of `rst_n`, both registers reload on the first rising edge. The first valid glyph appears on the second edge.
- Reset mid-stream discards the pipeline contents; no stale glyph reappears after release.
- Inputs changing every cycle produce one glyph per cycle, delayed by 2 cycles. Nothing is dropped or merged.
- `RE` and `RS` changes follow the same 2-cycle latency as data changes.

## Structure

- Package `echo_pkg` holds:
  - the code constants `CODE_BLANK`=00000 and `CODE_DASH`=00001, plus the valid-bit position;
  - the 16-entry glyph constant table;
  - the segment constants `SEG_OFF` and `SEG_DASH`.
- Sub-module `echo_codificador`:
  - ports `clk`, `rst_n`, `RE`, `RS`, `A`..`D`, `S1`..`S5`;
  - combinational priority encode followed by a 5-bit register.
- Sub-module `echo_display`:
  - ports `clk`, `rst_n`, `SD1`..`SD5`, `a`..`g`;
  - combinational decode via the package table followed by a 7-bit register.
- Top `echo_encoder_display` instantiates both and ties the encoder S1..S5 to the display SD1..SD5.

## Test plan

1. **Reset:**
   - Assert `rst_n`=0 mid-cycle with inputs RE=1, A..D=1111 → S=00000 and a..g=0000000 immediately.
   - Release `rst_n`, then apply 2 edges → S=11111, a..g=1000111 ("F").
2. **Full sweep:** RE=1, RS=0, ABCD=0000..1111, one value per cycle.
   - S equals `{1,ABCD}` one cycle after each input.
   - a..g matches the glyph list two cycles after each input, e.g. 0101 → 1011011 and 1011 → 0011111.
3. **Blank priority:**
   - RE=0, RS=1, ABCD=1000 → S=00000, a..g=0000000.
   - Then RE=1, RS=0 → S=11000, a..g=1111111.
4. **Dash:** RE=1, RS=1, ABCD=0111 → S=00001, a..g=0000001. Toggling ABCD while RS=1 leaves the outputs unchanged.
5. **Latency:** single-cycle pulse ABCD=0001 between 0000s (RE=1, RS=0).
   - Exactly one cycle of "1" (0110000) appears on a..g, two edges after the pulse.
   - Neighbouring cycles show "0" (1111110).
6. **Reset mid-stream:** assert `rst_n` while the sweep is running → both registers clear at once; after release, the output resumes from the current inputs with 2-cycle latency.
